// File: rtl/output_rate_buffer_pkg.sv
// Shared filter-chain definitions: default sample/FIFO widths and the pacing FSM encoding.
package output_rate_buffer_pkg;

    localparam int DefDataWidth = 18;
    localparam int DefAddrWidth = 4;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } paceState_t;

endpackage

// File: rtl/output_rate_buffer_fifo.sv
// Circular-RAM FIFO with wrapping read/write pointers and a separate occupancy counter.
module rateBufferFifo
    import output_rate_buffer_pkg::*;
#(
    parameter int DataWidth = DefDataWidth,
    parameter int AddrWidth = DefAddrWidth
) (
    input  logic                 Clk_i,
    input  logic                 Rst_i,
    input  logic                 wrEn,
    input  logic [DataWidth-1:0] wrData,
    input  logic                 rdEn,
    output logic [DataWidth-1:0] rdData,
    output logic [AddrWidth:0]   level,
    output logic                 full,
    output logic                 empty
);

    localparam int Depth = 2 ** AddrWidth;
    localparam logic [AddrWidth:0] DepthL = (AddrWidth + 1)'(Depth);

    logic [DataWidth-1:0] ram [Depth];
    logic [AddrWidth-1:0] wrPtr;
    logic [AddrWidth-1:0] rdPtr;

    assign rdData = ram[rdPtr];
    assign full   = (level == DepthL);
    assign empty  = (level == '0);

    // RAM is not reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge Clk_i) begin
        if (wrEn) ram[wrPtr] <= wrData;
    end

    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (wrEn) wrPtr <= wrPtr + 1'b1;
            if (rdEn) rdPtr <= rdPtr + 1'b1;
            case ({wrEn, rdEn})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/output_rate_buffer.sv
// Absorbs bursty interpolator samples and re-emits them at one sample per RateDiv clocks.
module output_rate_buffer
    import output_rate_buffer_pkg::*;
#(
    parameter int DataWidth = DefDataWidth,
    parameter int AddrWidth = DefAddrWidth,
    parameter int RateDiv   = 500
) (
    input  logic                        Clk_i,
    input  logic                        Rst_i,
    input  logic signed [DataWidth-1:0] Data_i,
    input  logic                        DataNd_i,
    input  logic                        ClearFlags_i,
    output logic signed [DataWidth-1:0] Data_o,
    output logic                        DataValid_o,
    output logic [AddrWidth:0]          Level_o,
    output logic                        Overflow_o,
    output logic                        Underflow_o
);

    localparam int CntW = (RateDiv > 1) ? $clog2(RateDiv) : 1;
    localparam logic [CntW-1:0] TickVal = CntW'(RateDiv - 1);
    localparam logic [AddrWidth:0] HalfDepth = (AddrWidth + 1)'(2 ** (AddrWidth - 1));

    paceState_t           state;
    logic [CntW-1:0]      tickCnt;
    logic                 tick;
    logic                 pop;
    logic                 underTick;
    logic                 wrAccept;
    logic                 wrDrop;
    logic                 full;
    logic                 empty;
    logic [DataWidth-1:0] rdData;

    assign tick      = (tickCnt == TickVal);
    assign pop       = (state == RUN) && tick && !empty;
    assign underTick = (state == RUN) && tick && empty;
    // A pop in the same cycle frees a slot, so a full FIFO still takes the write.
    assign wrAccept  = DataNd_i && (!full || pop);
    assign wrDrop    = DataNd_i && !wrAccept;

    rateBufferFifo #(
        .DataWidth(DataWidth),
        .AddrWidth(AddrWidth)
    ) uFifo (
        .Clk_i (Clk_i),
        .Rst_i (Rst_i),
        .wrEn  (wrAccept),
        .wrData(Data_i),
        .rdEn  (pop),
        .rdData(rdData),
        .level (Level_o),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            tickCnt     <= '0;
            state       <= FILL;
            Data_o      <= '0;
            DataValid_o <= 1'b0;
            Overflow_o  <= 1'b0;
            Underflow_o <= 1'b0;
        end else begin
            tickCnt <= tick ? '0 : tickCnt + 1'b1;

            case (state)
                FILL:    if (Level_o >= HalfDepth) state <= RUN;
                RUN:     if (underTick) state <= FILL;
                default: state <= FILL;
            endcase

            DataValid_o <= pop;
            if (pop) Data_o <= rdData;

            // Setting events outrank a same-cycle clear.
            if (wrDrop)            Overflow_o <= 1'b1;
            else if (ClearFlags_i) Overflow_o <= 1'b0;

            if (underTick)         Underflow_o <= 1'b1;
            else if (ClearFlags_i) Underflow_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_output_rate_buffer.sv
// Queue-based reference model plus directed scenarios and randomized bursty traffic.
module tb_output_rate_buffer;

    localparam int DW = 18;
    localparam int AW = 4;
    localparam int RD = 500;
    localparam int DEPTH = 16;

    logic                 Clk_i = 1'b0;
    logic                 Rst_i = 1'b0;
    logic signed [DW-1:0] Data_i = '0;
    logic                 DataNd_i = 1'b0;
    logic                 ClearFlags_i = 1'b0;
    logic signed [DW-1:0] Data_o;
    logic                 DataValid_o;
    logic [AW:0]          Level_o;
    logic                 Overflow_o;
    logic                 Underflow_o;

    output_rate_buffer #(.DataWidth(DW), .AddrWidth(AW), .RateDiv(RD)) dut (
        .Clk_i       (Clk_i),
        .Rst_i       (Rst_i),
        .Data_i      (Data_i),
        .DataNd_i    (DataNd_i),
        .ClearFlags_i(ClearFlags_i),
        .Data_o      (Data_o),
        .DataValid_o (DataValid_o),
        .Level_o     (Level_o),
        .Overflow_o  (Overflow_o),
        .Underflow_o (Underflow_o)
    );

    always #5 Clk_i = ~Clk_i;

    int nCmp = 0;
    int nFail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a sample queue, a phase count since reset, and a running flag.
    logic signed [DW-1:0] q[$];
    int                   mCnt = 0;
    bit                   mRun = 0;
    logic signed [DW-1:0] mData = '0;
    bit                   mValid = 0;
    bit                   mOvf = 0;
    bit                   mUnd = 0;

    always @(posedge Clk_i or negedge Rst_i) begin
        bit tk, pp, un, acc;
        int sz;
        if (!Rst_i) begin
            q.delete();
            mCnt = 0; mRun = 0; mData = '0; mValid = 0; mOvf = 0; mUnd = 0;
        end else begin
            sz  = q.size();
            tk  = (mCnt == RD - 1);
            pp  = mRun && tk && sz > 0;
            un  = mRun && tk && sz == 0;
            acc = DataNd_i && (sz < DEPTH || pp);
            mValid = pp;
            if (pp) mData = q.pop_front();
            if (acc) q.push_back(Data_i);
            if (DataNd_i && !acc) mOvf = 1; else if (ClearFlags_i) mOvf = 0;
            if (un) mUnd = 1; else if (ClearFlags_i) mUnd = 0;
            if (!mRun && sz >= DEPTH / 2) mRun = 1; else if (un) mRun = 0;
            mCnt = (mCnt + 1) % RD;
        end
    end

    logic signed [DW-1:0] outLog[$];
    time                  vTimes[$];

    always @(negedge Clk_i) begin
        chk("Data_o", Data_o, mData);
        chk("DataValid_o", DataValid_o, mValid);
        chk("Level_o", Level_o, q.size());
        chk("Overflow_o", Overflow_o, mOvf);
        chk("Underflow_o", Underflow_o, mUnd);
        if (DataValid_o) begin
            outLog.push_back(Data_o);
            vTimes.push_back($time);
        end
    end

    // Stimulus moves 1ns after the falling edge so the compare process has already sampled.
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge Clk_i);
            #1;
        end
    endtask

    task automatic wr(input logic signed [DW-1:0] d);
        Data_i = d;
        DataNd_i = 1'b1;
        cyc(1);
        DataNd_i = 1'b0;
    endtask

    task automatic waitVal(input string name, input int n, input int budget);
        for (int i = 0; i < budget && outLog.size() < n; i++) cyc(1);
        chk(name, outLog.size() >= n, 1);
    endtask

    initial begin
        int rates[6];
        bit hit;
        rates = '{4, 1, 2, 3, 1, 5};

        // Reset state
        cyc(3);
        chk("rst Level_o", Level_o, 0);
        chk("rst DataValid_o", DataValid_o, 0);
        chk("rst Data_o", Data_o, 0);
        chk("rst Overflow_o", Overflow_o, 0);
        chk("rst Underflow_o", Underflow_o, 0);
        Rst_i = 1'b1;

        // Eight samples fill to half depth, then drain one per RD clocks in order
        for (int i = 1; i <= 8; i++) wr(DW'(i));
        waitVal("first drain timeout", 8, 9 * RD);
        for (int i = 0; i < outLog.size() && i < 8; i++) chk("drain order", outLog[i], i + 1);
        for (int i = 1; i < vTimes.size() && i < 8; i++) chk("strobe spacing", vTimes[i] - vTimes[i-1], RD * 10);

        // Next tick finds the FIFO empty
        cyc(RD + 1);
        chk("underflow set", Underflow_o, 1);
        chk("underflow Data_o held", Data_o, 8);
        chk("underflow Level_o", Level_o, 0);
        for (int i = 9; i <= 15; i++) wr(DW'(i));
        cyc(2 * RD);
        chk("no strobe below half", outLog.size(), 8);
        wr(DW'(16));
        waitVal("refill drain timeout", 11, 4 * RD);
        for (int i = 8; i < outLog.size() && i < 11; i++) chk("refill order", outLog[i], i + 1);
        chk("level before reset", Level_o, 5);

        // Asynchronous reset mid-stream
        @(posedge Clk_i);
        #2;
        Rst_i = 1'b0;
        #1;
        chk("async rst Level_o", Level_o, 0);
        chk("async rst Data_o", Data_o, 0);
        chk("async rst DataValid_o", DataValid_o, 0);
        chk("async rst Overflow_o", Overflow_o, 0);
        chk("async rst Underflow_o", Underflow_o, 0);
        cyc(2);
        Rst_i = 1'b1;
        outLog.delete();
        vTimes.delete();

        // Seventeen writes before the first tick: last one dropped
        for (int i = 0; i < 17; i++) wr(DW'(100 + i));
        chk("full Level_o", Level_o, 16);
        chk("overflow set", Overflow_o, 1);
        Data_i = DW'(500);
        DataNd_i = 1'b1;
        ClearFlags_i = 1'b1;
        cyc(1);
        DataNd_i = 1'b0;
        ClearFlags_i = 1'b0;
        chk("set beats clear", Overflow_o, 1);
        hit = 0;
        for (int i = 0; i < 20 * RD && !hit; i++) begin
            cyc(1);
            hit = Underflow_o;
        end
        chk("drain to underflow", hit, 1);
        chk("drained count", outLog.size(), 16);
        for (int i = 0; i < outLog.size() && i < 16; i++) chk("full drain order", outLog[i], 100 + i);
        ClearFlags_i = 1'b1;
        cyc(1);
        ClearFlags_i = 1'b0;
        chk("clear Overflow_o", Overflow_o, 0);
        chk("clear Underflow_o", Underflow_o, 0);

        // Write into a full FIFO on a popping tick
        hit = 0;
        for (int i = 0; i < 3 * RD && !hit; i++) begin
            if (q.size() == DEPTH && mRun && mCnt == RD - 1) begin
                wr(DW'(300 + i));
                hit = 1;
            end else if (q.size() < DEPTH) begin
                wr(DW'(300 + i));
            end else begin
                cyc(1);
            end
        end
        chk("full tick reached", hit, 1);
        chk("full tick Level_o", Level_o, 16);
        chk("full tick Overflow_o", Overflow_o, 0);
        chk("full tick DataValid_o", DataValid_o, 1);

        // Randomized bursty traffic at varying average write rates
        for (int seg = 0; seg < 6; seg++) begin
            for (int i = 0; i < 5000; i++) begin
                Data_i = DW'($urandom);
                DataNd_i = ($urandom_range(0, 999) < rates[seg]);
                ClearFlags_i = ($urandom_range(0, 299) == 0);
                cyc(1);
            end
        end
        DataNd_i = 1'b0;
        ClearFlags_i = 1'b0;
        cyc(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
